lsu_mem_master: RTL

- Load/store unit: the initiating end of the single-port, word-addressed data memory interface.
- Accepts one RV32I load/store request at a time from the core.
- Converts byte addresses to word addresses, sign/zero-extends loads, and builds SB/SH stores by read-modify-write, because the memory only writes whole words.
- Sits between the execute stage and the data memory. Handshake is a request/response pair.

---
 rtl/lsu_mem_master_if.sv | 27 ++
 rtl/lsu_mem_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory bus of the load/store unit.
// The master modport is the LSU's view; the slave modport is the core/memory side.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit driving a single-port word-addressed memory; SB/SH via read-modify-write.
// Optional LSU_STATS_EN adds load/store/error response counters.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_master_if.master  bus
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic illegal, misal, range_err;
        if (we) illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else    illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                            f3 == 3'b100 || f3 == 3'b101);
        misal     = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        range_err = {2'b00, a[31:2]} >= 32'(MEM_WORDS);
        return illegal || misal || range_err;
    endfunction

    function automatic logic signed [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                       input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return $signed({{24{b[7]}}, b});
            3'b100:  return $signed({24'b0, b});
            3'b001:  return $signed({{16{h[15]}}, h});
            3'b101:  return $signed({16'b0, h});
            default: return $signed(word);
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] w;
        w = old;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    w[7:0]   = wd[7:0];
                    2'd1:    w[15:8]  = wd[7:0];
                    2'd2:    w[23:16] = wd[7:0];
                    default: w[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) w[31:16] = wd[15:0];
                else         w[15:0]  = wd[15:0];
            end
            default: w = wd;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            data_q  <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_wdata;
                    rdata_d = 32'b0;
                    err_d   = req_error(bus.req_we, bus.req_funct3, bus.req_addr);
                    if (err_d)                        state_d = RESP;
                    else if (!bus.req_we)             state_d = LOAD;
                    else if (bus.req_funct3 == 3'b010) state_d = WRITE;
                    else                              state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = load_extend(f3_q, addr_q[1:0], bus.mem_rdata);
                state_d = RESP;
            end
            RMW_RD: begin
                data_d  = store_merge(f3_q, addr_q[1:0], bus.mem_rdata, data_q);
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response fields are forced to zero except during the single RESP cycle.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = (state_q == RESP) ? rdata_q : 32'b0;
    assign bus.resp_err   = (state_q == RESP) ? err_q : 1'b0;
    assign bus.mem_addr   = {2'b00, addr_q[31:2]};
    assign bus.mem_wdata  = (state_q == WRITE) ? data_q : 32'b0;
    assign bus.mem_we     = (state_q == WRITE) & ~rst;

`ifdef LSU_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= 32'b0;
            stores_q <= 32'b0;
            errs_q   <= 32'b0;
        end else if (state_q == RESP) begin
            if (err_q)     errs_q   <= errs_q + 32'd1;
            else if (we_q) stores_q <= stores_q + 32'd1;
            else           loads_q  <= loads_q + 32'd1;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule
